// File: rtl/decode_queue.sv
// Instruction decoder with a DEPTH-entry packet FIFO, RET halt, flush and backpressure.
// Optional perf counters enabled by defining DECODE_PERF_CNT_EN.
module decode_queue #(
    parameter int REG_W = 4,
    parameter int IMM_W = 16,
    parameter int DEPTH = 4,
    parameter int TAG_W = 2,
    localparam int INSTR_W = 4 + 3 * REG_W,
    localparam int PKT_W   = IMM_W + 3 * REG_W + 19 + TAG_W,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PKT_W-1:0]   out_packet,
    input  logic               flush,
    input  logic               resume,
    output logic               halted,
    output logic [CW-1:0]      count
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]        perf_decoded,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_halt
`endif
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [3:0] OP_BRNZP   = 4'd1;
    localparam logic [3:0] OP_CMP     = 4'd2;
    localparam logic [3:0] OP_ADD     = 4'd3;
    localparam logic [3:0] OP_SUB     = 4'd4;
    localparam logic [3:0] OP_MUL     = 4'd5;
    localparam logic [3:0] OP_DIV     = 4'd6;
    localparam logic [3:0] OP_LDR     = 4'd7;
    localparam logic [3:0] OP_STR     = 4'd8;
    localparam logic [3:0] OP_CONST   = 4'd9;
    localparam logic [3:0] OP_TILE_LD = 4'd10;
    localparam logic [3:0] OP_TILE_ST = 4'd11;
    localparam logic [3:0] OP_MMA     = 4'd14;
    localparam logic [3:0] OP_RET     = 4'd15;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [PKT_W-1:0]  r_mem [DEPTH];

    logic              w_push;
    logic              w_pop;
    logic [3:0]        w_opcode;
    logic [REG_W-1:0]  w_rd;
    logic [REG_W-1:0]  w_rs;
    logic [REG_W-1:0]  w_rt;
    logic [2:0]        w_nzp;
    logic [IMM_W-1:0]  w_imm;
    logic              w_tensor;
    logic              w_ret;
    logic              w_pc_mux;
    logic              w_alu_out_mux;
    logic [1:0]        w_arith;
    logic [1:0]        w_reg_mux;
    logic              w_nzp_we;
    logic              w_mem_we;
    logic              w_mem_re;
    logic              w_reg_we;
    logic [PKT_W-1:0]  w_pkt;

    // in_ready depends only on registered state and flush, never on out_ready
    assign in_ready   = (r_state == S_RUN) && (r_count < CW'(DEPTH)) && !flush;
    assign out_valid  = (r_count != '0);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready && !flush;
    assign out_packet = r_mem[r_rd_ptr];
    assign halted     = (r_state == S_HALT);
    assign count      = r_count;

    assign w_opcode = in_instr[INSTR_W-1 -: 4];
    assign w_rd     = in_instr[3*REG_W-1 -: REG_W];
    assign w_rs     = in_instr[2*REG_W-1 -: REG_W];
    assign w_rt     = in_instr[REG_W-1:0];
    assign w_nzp    = w_rd[REG_W-1 -: 3];
    assign w_imm    = IMM_W'($signed(in_instr[2*REG_W-1:0]));

    always_comb begin
        w_tensor      = 1'b0;
        w_ret         = 1'b0;
        w_pc_mux      = 1'b0;
        w_alu_out_mux = 1'b0;
        w_arith       = 2'b00;
        w_reg_mux     = 2'b00;
        w_nzp_we      = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_re      = 1'b0;
        w_reg_we      = 1'b0;
        unique case (w_opcode)
            OP_BRNZP: w_pc_mux = 1'b1;
            OP_CMP: begin
                w_alu_out_mux = 1'b1;
                w_nzp_we      = 1'b1;
            end
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                w_reg_we = 1'b1;
                w_arith  = 2'(w_opcode - OP_ADD);
            end
            OP_LDR, OP_TILE_LD: begin
                w_reg_we  = 1'b1;
                w_reg_mux = 2'b01;
                w_mem_re  = 1'b1;
            end
            OP_STR, OP_TILE_ST: w_mem_we = 1'b1;
            OP_CONST: begin
                w_reg_we  = 1'b1;
                w_reg_mux = 2'b10;
            end
            OP_MMA: w_tensor = 1'b1;
            OP_RET: w_ret = 1'b1;
            default: ;
        endcase
    end

    assign w_pkt = {in_tag, w_opcode, w_tensor, w_ret, w_pc_mux,
                    w_alu_out_mux, w_arith, w_reg_mux, w_nzp_we,
                    w_mem_we, w_mem_re, w_reg_we, w_nzp,
                    w_rd, w_rs, w_rt, w_imm};

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN:  if (w_push && w_ret)    w_state_nxt = S_HALT;
            S_HALT: if (resume || flush)    w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_pkt;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    // Counters survive flush; only reset_n clears them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_decoded <= '0;
            perf_stall   <= '0;
            perf_halt    <= '0;
        end else begin
            if (w_push) perf_decoded <= perf_decoded + 32'd1;
            if (in_valid && !in_ready && (r_state == S_RUN))
                perf_stall <= perf_stall + 32'd1;
            if (r_state == S_HALT) perf_halt <= perf_halt + 32'd1;
        end
    end
`endif

endmodule
